// File: rtl/encoder_sequencer_if.sv
// Handshake bundle between the encoder sequencer and its round/writeback datapath.
interface encoder_sequencer_if;
  logic       start;
  logic       done1, done2, done3, done4, done5;
  logic       inreg_en;
  logic       colParity_en, rotate_en, permute_en, revaluate_en, addRC_en;
  logic       cnt_rst_24, cnt_en_24;
  logic       wr_en;
  logic [5:0] line_addr;
  logic [4:0] round;
  logic       busy, done, error;

  modport master (
    output start, done1, done2, done3, done4, done5,
    input  inreg_en, colParity_en, rotate_en, permute_en, revaluate_en, addRC_en,
    input  cnt_rst_24, cnt_en_24, wr_en, line_addr, round, busy, done, error
  );

  modport slave (
    input  start, done1, done2, done3, done4, done5,
    output inreg_en, colParity_en, rotate_en, permute_en, revaluate_en, addRC_en,
    output cnt_rst_24, cnt_en_24, wr_en, line_addr, round, busy, done, error
  );
endinterface

// File: rtl/encoder_sequencer.sv
// Block sequencer: load, ROUNDS x five-stage round loop, LINES-long writeback, done pulse.
// Optional per-stage watchdog enabled by defining ENCODER_SEQ_WATCHDOG_EN.
module encoder_sequencer #(
  parameter int unsigned ROUNDS  = 24,
  parameter int unsigned LINES   = 64,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic                 clk,
  input logic                 rst,
  encoder_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StColp, StRot, StPerm, StReval, StAddrc, StNext, StWrite, StFin
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] round_q, round_d;
  logic [5:0] line_q, line_d;
  logic       own_done;

  // Only the active stage's strobe is looked at; all others are don't-care.
  always_comb begin
    own_done = 1'b0;
    case (state_q)
      StColp:  own_done = bus.done1;
      StRot:   own_done = bus.done2;
      StPerm:  own_done = bus.done3;
      StReval: own_done = bus.done4;
      StAddrc: own_done = bus.done5;
      default: own_done = 1'b0;
    endcase
  end

`ifdef ENCODER_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WdW-1:0] wd_q, wd_d;
  logic           error_q, error_d;
  logic           in_stage, wd_trip;

  assign in_stage = state_q inside {StColp, StRot, StPerm, StReval, StAddrc};
  assign wd_trip  = in_stage && !own_done && (wd_q == WdW'(TIMEOUT - 1));

  // Counter restarts whenever a stage is left, so every stage entry sees zero.
  always_comb begin
    wd_d    = (in_stage && !own_done && !wd_trip) ? wd_q + WdW'(1) : '0;
    error_d = error_q;
    if (state_q == StIdle && bus.start) error_d = 1'b0;
    if (wd_trip)                        error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.error      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    line_d  = line_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          round_d = '0;
          line_d  = '0;
        end
      end
      StLoad:  state_d = StColp;
      StColp:  if (own_done) state_d = StRot;
      StRot:   if (own_done) state_d = StPerm;
      StPerm:  if (own_done) state_d = StReval;
      StReval: if (own_done) state_d = StAddrc;
      StAddrc: if (own_done) state_d = (round_q == 5'(ROUNDS - 1)) ? StWrite : StNext;
      StNext: begin
        round_d = round_q + 5'd1;
        state_d = StColp;
      end
      StWrite: begin
        if (line_q == 6'(LINES - 1)) begin
          line_d  = '0;
          state_d = StFin;
        end else begin
          line_d = line_q + 6'd1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef ENCODER_SEQ_WATCHDOG_EN
    if (wd_trip) state_d = StIdle;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      line_q  <= line_d;
    end
  end

  // Outputs decode the registered state only; no input reaches them combinationally.
  always_comb begin
    bus.inreg_en     = (state_q == StLoad);
    bus.cnt_rst_24   = (state_q == StLoad);
    bus.colParity_en = (state_q == StColp);
    bus.rotate_en    = (state_q == StRot);
    bus.permute_en   = (state_q == StPerm);
    bus.revaluate_en = (state_q == StReval);
    bus.addRC_en     = (state_q == StAddrc);
    bus.cnt_en_24    = (state_q == StNext);
    bus.wr_en        = (state_q == StWrite);
    bus.done         = (state_q == StFin);
    bus.busy         = (state_q != StIdle);
    bus.round        = round_q;
    bus.line_addr    = line_q;
  end

endmodule

// File: tb/tb_encoder_sequencer.sv
// Randomized bench: expected per-cycle output traces are built from the block schedule.
module tb_encoder_sequencer;
  localparam int unsigned Rounds = 24;
  localparam int unsigned Lines  = 64;

  typedef struct packed {
    logic [22:0] exp;
    logic [4:0]  dn;
    logic        st;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_bad = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  encoder_sequencer_if bus ();
  encoder_sequencer_if bus1 ();

  encoder_sequencer #(.ROUNDS(Rounds), .LINES(Lines), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  encoder_sequencer #(.ROUNDS(1), .LINES(4), .TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {inreg, colp, rot, perm, reval, addrc, cnt_rst, cnt_en, wr, line[5:0], round[4:0],
  //  busy, done, error}
  function automatic logic [22:0] obs();
    return {bus.inreg_en, bus.colParity_en, bus.rotate_en, bus.permute_en, bus.revaluate_en,
            bus.addRC_en, bus.cnt_rst_24, bus.cnt_en_24, bus.wr_en, bus.line_addr, bus.round,
            bus.busy, bus.done, bus.error};
  endfunction

  function automatic logic [22:0] vec(logic [8:0] s, logic [5:0] la, logic [4:0] rd,
                                      logic dn);
    return {s, la, rd, 1'b1, dn, 1'b0};
  endfunction

  task automatic check_idle(input string tag);
    logic [22:0] o;
    o = obs();
    check(tag, {o[22:14], o[2:0]}, {9'b0, 2'b00, err_exp});
  endtask

  task automatic drive_dones(input logic [4:0] d);
    {bus.done5, bus.done4, bus.done3, bus.done2, bus.done1} = d;
  endtask

  // mode[1:0]: foreign done noise (0 none, 1 random, 2 all held high); mode[2]: start held high
  task automatic run_block(input int abort_round, input int mode);
    ent_t        tr[$];
    ent_t        e;
    int          abort_idx;
    int          d;
    logic [4:0]  own;
    logic [4:0]  noise;
    abort_idx = -1;
    e.exp = vec(9'b100000100, 6'd0, 5'd0, 1'b0);
    e.dn  = 5'd0;
    e.st  = 1'b0;
    tr.push_back(e);
    for (int r = 0; r < Rounds; r++) begin
      for (int s = 0; s < 5; s++) begin
        d   = $urandom_range(1, 4);
        own = 5'(1 << s);
        if (s == 2 && r == abort_round) abort_idx = tr.size();
        for (int k = 0; k < d; k++) begin
          case (mode & 3)
            0:       noise = 5'd0;
            1:       noise = 5'($urandom);
            default: noise = 5'h1f;
          endcase
          e.exp = vec(9'(1 << (7 - s)), 6'd0, 5'(r), 1'b0);
          e.dn  = (noise & ~own) | ((k == d - 1) ? own : 5'd0);
          e.st  = ((mode & 4) != 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
          tr.push_back(e);
        end
      end
      if (r < Rounds - 1) begin
        e.exp = vec(9'b000000010, 6'd0, 5'(r), 1'b0);
        e.dn  = 5'($urandom);
        tr.push_back(e);
      end
    end
    for (int l = 0; l < Lines; l++) begin
      e.exp = vec(9'b000000001, 6'(l), 5'(Rounds - 1), 1'b0);
      e.dn  = 5'($urandom);
      tr.push_back(e);
    end
    e.exp = vec(9'b0, 6'd0, 5'(Rounds - 1), 1'b1);
    e.st  = 1'b1;
    tr.push_back(e);

    @(negedge clk);
    check_idle("pre_idle");
    bus.start = 1'b1;
    err_exp   = 1'b0;
    foreach (tr[i]) begin
      @(negedge clk);
      check($sformatf("seq%0d", i), 32'(obs()), 32'(tr[i].exp));
      if (i == abort_idx) begin
        #2 rst = 1'b1;
        bus.start = 1'b0;
        drive_dones(5'd0);
        #1 check("rst_all_zero", 32'(obs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("post_rst_idle", 32'(obs()), 32'd0);
        end
        return;
      end
      drive_dones(tr[i].dn);
      bus.start = tr[i].st;
    end
    @(negedge clk);
    bus.start = 1'b0;
    drive_dones(5'd0);
    check_idle("post_idle");
  endtask

  task automatic run_unit();
    int lat, ncnt, ndone;
    lat = 0; ncnt = 0; ndone = 0;
    @(negedge clk);
    check_idle("unit_pre");
    bus.start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.cnt_en_24) ncnt++;
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      drive_dones({bus.addRC_en, bus.revaluate_en, bus.permute_en, bus.rotate_en,
                   bus.colParity_en});
      if (!bus.busy) break;
    end
    drive_dones(5'd0);
    check("unit_latency", lat, 209);
    check("unit_cnt_en", ncnt, 23);
    check("unit_done_pulses", ndone, 1);
    check_idle("unit_post");
  endtask

`ifdef ENCODER_SEQ_WATCHDOG_EN
  task automatic run_watchdog();
    int nrev, ndone;
    nrev = 0; ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.revaluate_en) nrev++;
      if (bus.done) ndone++;
      drive_dones({bus.addRC_en, 1'b0, bus.permute_en, bus.rotate_en, bus.colParity_en});
      if (!bus.busy) break;
    end
    drive_dones(5'd0);
    check("wd_reval_cycles", nrev, 15);
    check("wd_error", bus.error, 1);
    check("wd_reval_en_low", bus.revaluate_en, 0);
    check("wd_no_done", ndone, 0);
    err_exp = 1'b1;
    check_idle("wd_idle");
  endtask
`endif

  task automatic run_r1();
    int lat, ncnt, nwr, first_wr;
    lat = 0; ncnt = 0; nwr = 0; first_wr = 0;
    @(negedge clk);
    bus1.start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.cnt_en_24) ncnt++;
      if (bus1.wr_en) begin
        if (first_wr == 0) first_wr = c;
        check("r1_line_addr", bus1.line_addr, nwr);
        nwr++;
      end
      if (bus1.done && lat == 0) lat = c;
      {bus1.done5, bus1.done4, bus1.done3, bus1.done2, bus1.done1} =
        {bus1.addRC_en, bus1.revaluate_en, bus1.permute_en, bus1.rotate_en, bus1.colParity_en};
      if (!bus1.busy) break;
    end
    {bus1.done5, bus1.done4, bus1.done3, bus1.done2, bus1.done1} = 5'd0;
    check("r1_latency", lat, 11);
    check("r1_cnt_en", ncnt, 0);
    check("r1_first_write", first_wr, 7);
    check("r1_lines", nwr, 4);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    drive_dones(5'd0);
    {bus1.done5, bus1.done4, bus1.done3, bus1.done2, bus1.done1} = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(obs()), 32'd0);
    check("reset_busy1", bus1.busy, 0);
    rst = 1'b0;

    run_unit();
    run_block(-1, 2);
    run_block(-1, 4);
    run_block(10, 1);
    for (int b = 0; b < 3; b++) run_block(-1, 1);
`ifdef ENCODER_SEQ_WATCHDOG_EN
    run_watchdog();
`endif
    run_block(-1, 0);
    run_r1();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/encoder_sequencer.md
ENCODER_SEQUENCER -- requirements
Module: encoder_sequencer

Interface
REQ-001 SHALL have parameter ROUNDS, default 24, number of round iterations per block (legal 1..31).
REQ-002 SHALL have parameter LINES, default 64, number of 25-bit lines written back per block.
REQ-003 SHALL have parameter TIMEOUT, default 1023, max cycles per stage before watchdog trip (used only under REQ-030).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to encode one block; sampled in IDLE only.
REQ-007 done1..done5  input  1 each  completion strobes from colParity, rotate, permute, revaluate, addRC units.
REQ-008 inreg_en  output  1  input register load strobe.
REQ-009 colParity_en, rotate_en, permute_en, revaluate_en, addRC_en  output  1 each  stage enables (one-hot or all zero).
REQ-010 cnt_rst_24, cnt_en_24  output  1 each  round counter reset / increment to datapath.
REQ-011 wr_en  output  1  result-line write strobe; line_addr  output  6  line index.
REQ-012 round  output  5  current round index 0..ROUNDS-1; busy  output  1; done  output  1  block-complete pulse; error  output  1.

Function
REQ-013 States: IDLE, LOAD, COLP, ROT, PERM, REVAL, ADDRC, NEXT, WRITE, FIN.
REQ-014 IDLE: start=1 -> LOAD next cycle; otherwise stay; busy=0 only in IDLE.
REQ-015 LOAD: exactly one cycle; inreg_en=1, cnt_rst_24=1, round cleared to 0; -> COLP.
REQ-016 Each stage state asserts only its own enable, held high every cycle in that state.
REQ-017 Stage exit: own done=1 -> advance (COLP->ROT->PERM->REVAL->ADDRC); enable low on the following cycle; minimum 1 cycle per stage.
REQ-018 done strobes of non-active stages SHALL be ignored; simultaneous strobes resolved by active stage only.
REQ-019 ADDRC with done5=1: round==ROUNDS-1 -> WRITE, else -> NEXT.
REQ-020 NEXT: one cycle; cnt_en_24=1, round increments by 1; -> COLP.
REQ-021 WRITE: wr_en=1 every cycle, line_addr 0..LINES-1 incrementing per cycle; after LINES-1 -> FIN; no wrap within a block.
REQ-022 FIN: done=1 for exactly one cycle; -> IDLE; start in FIN ignored.
REQ-023 start while busy SHALL be ignored (not queued).
REQ-024 Outputs registered from state; no combinational path from start/done* to any output.
REQ-025 Total latency with all units completing in 1 cycle: 1 + ROUNDS*5 + (ROUNDS-1) + LINES + 1 cycles start->done.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, round=0, line_addr=0, all outputs 0, watchdog count 0.
REQ-027 Reset mid-operation abandons the block; no done pulse; next block requires fresh start.
REQ-028 rst has priority over every simultaneous input.
REQ-029 error is sticky, cleared only by rst or by start accepted in IDLE.

Configuration
REQ-030 Macro ENCODER_SEQ_WATCHDOG_EN defined: per-stage cycle counter reset on stage entry; reaching TIMEOUT without own done -> error=1, state -> IDLE, no done pulse.
REQ-031 Macro not defined: no watchdog counter instantiated, stages wait indefinitely, error tied 0.

Verification
REQ-032 ROUNDS=24, LINES=64, all done strobes returned 1 cycle after enable -> done pulse at 1+120+23+64+1=209 cycles after start; cnt_en_24 pulses 23 times.
REQ-033 done3 held high during COLP -> ignored; colParity_en stays 1 until done1; sequence unchanged.
REQ-034 start pulsed during ROT of round 5 -> no restart, round stays 5, single done at end.
REQ-035 rst asserted in PERM of round 10 -> all outputs 0 same cycle, no done; new start completes normally from round 0.
REQ-036 ENCODER_SEQ_WATCHDOG_EN, TIMEOUT=15, done4 never returned -> error=1 after 15 REVAL cycles, revaluate_en low, back to IDLE; next start clears error.
REQ-037 ROUNDS=1 -> no NEXT state, cnt_en_24 never asserted, WRITE entered after first ADDRC.
